// File: rtl/nn_beat_feeder.sv
// nn_beat_feeder: packs a serial byte stream into LANES-wide beats and sends
// them segment by segment (input features, layer-1 neurons, layer-2 neurons)
// to the NN controller, which releases each following segment with seg_go.
module nn_beat_feeder #(
    parameter int unsigned LANES      = 50,
    parameter int unsigned DW         = 8,
    parameter int unsigned IN_BEATS   = 20,
    parameter int unsigned L1_BEATS   = 21,
    parameter int unsigned L1_NEURONS = 100,
    parameter int unsigned L2_BEATS   = 3,
    parameter int unsigned L2_NEURONS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DW-1:0]         s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic [7:0]            count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  seg_last,
    input  logic                  seg_go,
    output logic [7:0]            seg_id,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int unsigned BW       = LANES * DW;
    localparam int unsigned PTR_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);
    localparam logic [7:0]       LAST_SEG = 8'(L1_NEURONS + L2_NEURONS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_GO,
        ST_DONE
    } state_t;

    // Index of the final beat of the segment selected by id.
    function automatic logic [7:0] seg_last_idx(input logic [7:0] id);
        logic [7:0] r;
        if (id == 8'd0) begin
            r = 8'(IN_BEATS - 1);
        end else if (id <= 8'(L1_NEURONS)) begin
            r = 8'(L1_BEATS - 1);
        end else begin
            r = 8'(L2_BEATS - 1);
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [BW-1:0]    pack_buf_q, pack_buf_d;
    logic [PTR_W-1:0] lane_ptr_q, lane_ptr_d;
    logic             pack_full_q, pack_full_d;
    logic [BW-1:0]    out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       seg_id_q, seg_id_d;
    logic             seg_last_q, seg_last_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;
    logic             s_ready_q, s_ready_d;

    logic             accept;
    logic             consume;
    logic             last_beat;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pack_buf_q   <= '0;
            lane_ptr_q   <= '0;
            pack_full_q  <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            count_q      <= '0;
            seg_id_q     <= '0;
            seg_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            s_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pack_buf_q   <= pack_buf_d;
            lane_ptr_q   <= lane_ptr_d;
            pack_full_q  <= pack_full_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            count_q      <= count_d;
            seg_id_q     <= seg_id_d;
            seg_last_q   <= seg_last_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            s_ready_q    <= s_ready_d;
        end
    end

    // Next-state: byte packing, beat hand-off, segment sequencing.
    always_comb begin
        state_d      = state_q;
        pack_buf_d   = pack_buf_q;
        lane_ptr_d   = lane_ptr_q;
        pack_full_d  = pack_full_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        count_d      = count_q;
        seg_id_d     = seg_id_q;
        frame_done_d = 1'b0;

        accept    = s_valid && s_ready_q;
        consume   = out_valid_q && out_ready;
        last_beat = (count_q == seg_last_idx(seg_id_q));

        // Bytes land in the pack buffer; the final lane marks the beat complete.
        if (accept) begin
            pack_buf_d[32'(lane_ptr_q) * DW +: DW] = s_data;
            if (lane_ptr_q == PTR_LAST) begin
                lane_ptr_d  = '0;
                pack_full_d = 1'b1;
            end else begin
                lane_ptr_d = lane_ptr_q + PTR_W'(1);
            end
        end

        if (consume) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SEND;
                    seg_id_d    = '0;
                    count_d     = '0;
                    lane_ptr_d  = '0;
                    pack_full_d = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (consume) begin
                    if (last_beat) begin
                        count_d = '0;
                        if (seg_id_q == LAST_SEG) begin
                            state_d = ST_DONE;
                        end else begin
                            seg_id_d = seg_id_q + 8'd1;
                            state_d  = ST_WAIT_GO;
                        end
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
                // A completed beat (including one finishing this cycle) moves out
                // unless the current segment is closing; that beat waits for seg_go.
                if (pack_full_d && (!out_valid_q || consume) && !(consume && last_beat)) begin
                    out_data_d  = pack_buf_d;
                    out_valid_d = 1'b1;
                    pack_full_d = 1'b0;
                end
            end
            ST_WAIT_GO: begin
                count_d     = '0;
                out_valid_d = 1'b0;
                if (seg_go) begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d == ST_SEND) || (state_d == ST_WAIT_GO);
        frame_done_d = (state_d == ST_DONE);
        s_ready_d    = busy_d && !pack_full_d;
        seg_last_d   = out_valid_d && (count_d == seg_last_idx(seg_id_d));
    end

    assign s_ready    = s_ready_q;
    assign out_data   = out_data_q;
    assign count      = count_q;
    assign out_valid  = out_valid_q;
    assign seg_last   = seg_last_q;
    assign seg_id     = seg_id_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nn_beat_feeder.sv
// Directed bench for nn_beat_feeder; a reduced layer-1 neuron count keeps a
// whole frame short while exercising every segment type.
module tb_nn_beat_feeder;

    localparam int unsigned LANES    = 50;
    localparam int unsigned DW       = 8;
    localparam int unsigned W        = LANES * DW;
    localparam int unsigned IN_BEATS = 20;
    localparam int unsigned L1_BEATS = 21;
    localparam int unsigned L1_N     = 6;
    localparam int unsigned L2_BEATS = 3;
    localparam int unsigned L2_N     = 2;
    localparam int unsigned NSEG     = 1 + L1_N + L2_N;
    localparam int unsigned LAST_SEG = L1_N + L2_N;
    localparam int unsigned TOTAL    = LANES * (IN_BEATS + L1_N * L1_BEATS + L2_N * L2_BEATS);

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [DW-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] out_data;
    logic [7:0]   count;
    logic         out_valid;
    logic         out_ready;
    logic         seg_last;
    logic         seg_go;
    logic [7:0]   seg_id;
    logic         frame_done;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    int byte_idx, beat_no, exp_seg, exp_cnt, done_cnt, go_wait, gap_left;
    int seen [NSEG];
    bit go_auto, src_en;

    nn_beat_feeder #(
        .LANES(LANES), .DW(DW), .IN_BEATS(IN_BEATS), .L1_BEATS(L1_BEATS),
        .L1_NEURONS(L1_N), .L2_BEATS(L2_BEATS), .L2_NEURONS(L2_N)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .out_data(out_data), .count(count), .out_valid(out_valid), .out_ready(out_ready),
        .seg_last(seg_last), .seg_go(seg_go), .seg_id(seg_id),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int seg_len(input int s);
        if (s == 0) return IN_BEATS;
        else if (s <= int'(L1_N)) return L1_BEATS;
        else return L2_BEATS;
    endfunction

    function automatic logic [W-1:0] exp_beat(input int base);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < int'(LANES); k++) v[k*DW +: DW] = 8'((base + k) % 256);
        return v;
    endfunction

    task automatic model_clear();
        byte_idx = 0; beat_no = 0; exp_seg = 0; exp_cnt = 0;
        done_cnt = 0; go_wait = 0; gap_left = 0;
        for (int s = 0; s < int'(NSEG); s++) seen[s] = 0;
    endtask

    task automatic check_seg_counts();
        for (int s = 0; s < int'(NSEG); s++) check("seg_beats", W'(seen[s]), W'(seg_len(s)));
    endtask

    // One clock: score the beat consumed at this edge, update the model, redrive inputs.
    task automatic tick();
        logic acc, cons;
        acc  = (s_valid === 1'b1) && (s_ready === 1'b1) && !reset;
        cons = (out_valid === 1'b1) && out_ready && !reset;
        if (cons) begin
            check("beat_data", out_data, exp_beat(beat_no * int'(LANES)));
            check("beat_count", W'(count), W'(exp_cnt));
            check("beat_seg", W'(seg_id), W'(exp_seg));
            check("beat_last", W'(seg_last), W'(exp_cnt == seg_len(exp_seg) - 1));
        end
        @(posedge clk);
        #1;
        if (reset) begin
            model_clear();
        end else begin
            if (acc) byte_idx++;
            if (cons) begin
                seen[exp_seg]++;
                beat_no++;
                if (exp_cnt == seg_len(exp_seg) - 1) begin
                    exp_cnt = 0;
                    if (exp_seg == int'(LAST_SEG)) begin
                        check("done_pulse", W'(frame_done), W'(1));
                        check("done_busy", W'(busy), W'(0));
                    end else begin
                        exp_seg++;
                        go_wait = 3;
                        check("wait_valid", W'(out_valid), W'(0));
                        check("wait_count", W'(count), W'(0));
                        check("wait_seg", W'(seg_id), W'(exp_seg));
                    end
                end else begin
                    exp_cnt++;
                end
            end
        end
        if (frame_done === 1'b1) done_cnt++;
        start  = 1'b0;
        seg_go = 1'b0;
        if (go_wait > 0) begin
            go_wait--;
            if (go_wait == 0 && go_auto) seg_go = 1'b1;
        end
        if (gap_left > 0) gap_left--;
        s_valid = src_en && (gap_left == 0) && (byte_idx < int'(TOTAL));
        s_data  = 8'(byte_idx % 256);
    endtask

    initial begin
        int n;
        logic [W-1:0] d0;
        logic [7:0]   c0;
        int           b0;

        reset = 1'b1; start = 1'b0; s_data = '0; s_valid = 1'b0;
        out_ready = 1'b0; seg_go = 1'b0; go_auto = 1'b0; src_en = 1'b0;
        model_clear();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_count", W'(count), W'(0));
        check("rst_seg", W'(seg_id), W'(0));
        check("rst_last", W'(seg_last), W'(0));
        check("rst_done", W'(frame_done), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_sready", W'(s_ready), W'(0));
        check("rst_data", out_data, W'(0));

        // Stream offered while idle is not taken
        src_en = 1'b1;
        repeat (3) tick();
        check("idle_sready", W'(s_ready), W'(0));
        check("idle_noacc", W'(byte_idx), W'(0));

        // Frame 1: continuous stream, seg_go 3 cycles after each WAIT_GO entry
        model_clear();
        out_ready = 1'b1; go_auto = 1'b1;
        start = 1'b1;
        tick();
        check("f1_busy", W'(busy), W'(1));
        n = 0;
        while (byte_idx < int'(LANES) && n < 200) begin tick(); n++; end
        check("f1_lat_to", W'(n < 200), W'(1));
        check("f1_lat_valid", W'(out_valid), W'(1));
        check("f1_lane1", W'(out_data[7:0]), W'(8'h00));
        check("f1_lane50", W'(out_data[W-1:W-8]), W'(8'h31));
        check("f1_count0", W'(count), W'(0));
        n = 0;
        while (done_cnt == 0 && n < 20000) begin tick(); n++; end
        check("f1_done_to", W'(n < 20000), W'(1));
        repeat (3) tick();
        check("f1_done_once", W'(done_cnt), W'(1));
        check("f1_busy_end", W'(busy), W'(0));
        check("f1_seg_end", W'(seg_id), W'(LAST_SEG));
        check("f1_valid_end", W'(out_valid), W'(0));
        check_seg_counts();

        // Frame 2: output stall at count 7, then a stream gap
        model_clear();
        start = 1'b1;
        tick();
        n = 0;
        while (!(out_valid === 1'b1 && count == 8'd7) && n < 2000) begin tick(); n++; end
        check("stall_to", W'(n < 2000), W'(1));
        out_ready = 1'b0;
        d0 = out_data; c0 = count; b0 = byte_idx;
        for (int i = 0; i < 60; i++) begin
            tick();
            check("stall_data", out_data, d0);
            check("stall_count", W'(count), W'(c0));
            check("stall_valid", W'(out_valid), W'(1));
        end
        check("stall_bytes", W'(byte_idx - b0), W'(LANES));
        check("stall_sready", W'(s_ready), W'(0));
        out_ready = 1'b1;
        n = 0;
        while (byte_idx < 720 && n < 2000) begin tick(); n++; end
        check("gap_to", W'(n < 2000), W'(1));
        s_valid = 1'b0; gap_left = 30;
        repeat (5) tick();
        check("gap_valid_a", W'(out_valid), W'(0));
        check("gap_count_a", W'(count), W'(14));
        repeat (20) tick();
        check("gap_valid_b", W'(out_valid), W'(0));
        check("gap_count_b", W'(count), W'(14));

        // Reset in the middle of segment 5
        n = 0;
        while (!(out_valid === 1'b1 && seg_id == 8'd5 && count == 8'd10) && n < 10000) begin tick(); n++; end
        check("mid_to", W'(n < 10000), W'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", W'(out_valid), W'(0));
        check("mrst_count", W'(count), W'(0));
        check("mrst_busy", W'(busy), W'(0));
        check("mrst_sready", W'(s_ready), W'(0));
        check("mrst_seg", W'(seg_id), W'(0));
        repeat (3) tick();
        check("mrst_noacc", W'(byte_idx), W'(0));

        // Frame 3: replay from segment 0; stray seg_go/start are ignored
        model_clear();
        go_auto = 1'b0;
        start = 1'b1;
        tick();
        n = 0;
        while (exp_cnt < 5 && n < 2000) begin tick(); n++; end
        check("f3_to_a", W'(n < 2000), W'(1));
        seg_go = 1'b1; start = 1'b1;
        tick();
        n = 0;
        while (exp_seg == 0 && n < 2000) begin tick(); n++; end
        check("f3_to_b", W'(n < 2000), W'(1));
        repeat (60) tick();
        check("f3_hold_valid", W'(out_valid), W'(0));
        check("f3_hold_seg", W'(seg_id), W'(1));
        check("f3_hold_count", W'(count), W'(0));
        check("f3_prefetch", W'(byte_idx), W'(LANES * (IN_BEATS + 1)));
        check("f3_hold_sready", W'(s_ready), W'(0));
        go_auto = 1'b1;
        seg_go = 1'b1;
        tick();
        n = 0;
        while (done_cnt == 0 && n < 20000) begin tick(); n++; end
        check("f3_done_to", W'(n < 20000), W'(1));
        repeat (3) tick();
        check("f3_done_once", W'(done_cnt), W'(1));
        check("f3_busy_end", W'(busy), W'(0));
        check("f3_seg_end", W'(seg_id), W'(LAST_SEG));
        check_seg_counts();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
